// File: rtl/reg8file_seq_pkg.sv
// Shared definitions for the reg8file command sequencer.
//   - op encodings carried on cmd_op
//   - sequencer state encoding
//   - default data / register-select widths matching the 8x8 register file
package reg8file_seq_pkg;

    localparam int unsigned DEF_DW = 8;
    localparam int unsigned DEF_AW = 3;

    typedef enum logic [1:0] {
        OP_LDI = 2'b00,
        OP_MOV = 2'b01,
        OP_ADD = 2'b10,
        OP_CLR = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_IDLE = 3'd1,
        ST_RD1  = 3'd2,
        ST_RD2  = 3'd3,
        ST_WB   = 3'd4
    } state_e;

    // Cycles from the accept edge to the done pulse.
    function automatic int unsigned op_latency(op_e op);
        unique case (op)
            OP_MOV:  return 2;
            OP_ADD:  return 3;
            default: return 1;
        endcase
    endfunction

endpackage

// File: rtl/reg8file.sv
// 2**AW x DW register file.
//   clk   : clock, rising edge
//   clr   : synchronous clear of every register (wins over en)
//   en    : synchronous write enable
//   wsel  : write select
//   d     : write data
//   rsel  : read select
//   q     : combinational read data
module reg8file #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 3
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          en,
    input  logic [AW-1:0] wsel,
    input  logic [DW-1:0] d,
    input  logic [AW-1:0] rsel,
    output logic [DW-1:0] q
);

    localparam int unsigned NREG = 2 ** AW;

    logic [DW-1:0] regs_q [NREG];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (en) begin
            regs_q[wsel] <= d;
        end
    end

    assign q = regs_q[rsel];

endmodule

// File: rtl/reg8file_seq.sv
// Command sequencer owning the single write port and single read port of reg8file.
// Accepts one LDI / MOV / ADD / CLR command at a time over valid/ready and expands it into
// read cycles (RD1, RD2) and one write-back cycle (WB) on the register-file pins.
//
// Ports
//   clk, clr_n                 : clock (rising edge), asynchronous active-low reset
//   cmd_valid / cmd_ready      : command handshake; ready only in IDLE
//   cmd_op, cmd_rd, cmd_rs1,
//   cmd_rs2, cmd_imm           : command fields, latched on acceptance
//   rf_clr, rf_en, rf_wsel,
//   rf_d, rf_rsel              : register-file control (Moore-decoded)
//   rf_q                       : register-file combinational read data
//   busy                       : not in IDLE
//   done                       : one-cycle pulse in the write-back cycle
//   res, carry                 : last written value and last ADD carry-out
module reg8file_seq
    import reg8file_seq_pkg::*;
#(
    parameter int unsigned DW           = DEF_DW,
    parameter int unsigned AW           = DEF_AW,
    parameter bit          CLR_ON_RESET = 1'b1
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_rd,
    input  logic [AW-1:0] cmd_rs1,
    input  logic [AW-1:0] cmd_rs2,
    input  logic [DW-1:0] cmd_imm,
    output logic          rf_clr,
    output logic          rf_en,
    output logic [AW-1:0] rf_wsel,
    output logic [DW-1:0] rf_d,
    output logic [AW-1:0] rf_rsel,
    input  logic [DW-1:0] rf_q,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] res,
    output logic          carry
);

    localparam state_e RESET_STATE = CLR_ON_RESET ? ST_INIT : ST_IDLE;

    state_e        state_q, state_d;

    // Latched command fields
    op_e           op_q;
    logic [AW-1:0] rd_q;
    logic [AW-1:0] rs1_q;
    logic [AW-1:0] rs2_q;
    logic [DW-1:0] imm_q;

    // Operands captured during RD1 / RD2
    logic [DW-1:0] opa_q;
    logic [DW-1:0] opb_q;

    logic [DW-1:0] res_q;
    logic          carry_q;

    logic          accept;
    logic [DW:0]   sum;
    logic [DW-1:0] wb_data;

    // Output decode before reset gating
    logic          clr_raw;
    logic          en_raw;
    logic          done_raw;
    logic          ready_raw;

    assign accept = (state_q == ST_IDLE) && cmd_valid;
    assign sum    = {1'b0, opa_q} + {1'b0, opb_q};

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_INIT: state_d = ST_IDLE;
            ST_IDLE: begin
                if (cmd_valid) begin
                    unique case (op_e'(cmd_op))
                        OP_MOV, OP_ADD: state_d = ST_RD1;
                        default:        state_d = ST_WB;
                    endcase
                end
            end
            // Only MOV and ADD ever reach RD1.
            ST_RD1:  state_d = (op_q == OP_ADD) ? ST_RD2 : ST_WB;
            ST_RD2:  state_d = ST_WB;
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Write-back data selection
    // ------------------------------------------------------------------
    always_comb begin
        wb_data = '0;
        unique case (op_q)
            OP_LDI:  wb_data = imm_q;
            OP_MOV:  wb_data = opa_q;
            OP_ADD:  wb_data = sum[DW-1:0];
            default: wb_data = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Moore output decode from registered state and latched fields
    // ------------------------------------------------------------------
    always_comb begin
        clr_raw   = 1'b0;
        en_raw    = 1'b0;
        done_raw  = 1'b0;
        ready_raw = 1'b0;
        rf_wsel   = '0;
        rf_d      = '0;
        rf_rsel   = '0;
        unique case (state_q)
            ST_INIT: clr_raw = 1'b1;
            ST_IDLE: ready_raw = 1'b1;
            ST_RD1:  rf_rsel = rs1_q;
            ST_RD2:  rf_rsel = rs2_q;
            ST_WB: begin
                done_raw = 1'b1;
                if (op_q == OP_CLR) begin
                    clr_raw = 1'b1;
                end else begin
                    en_raw  = 1'b1;
                    rf_wsel = rd_q;
                    rf_d    = wb_data;
                end
            end
            default: ;
        endcase
    end

    // The reset state is INIT, whose decode would otherwise drive rf_clr while clr_n is low.
    assign rf_clr    = clr_raw & clr_n;
    assign rf_en     = en_raw & clr_n;
    assign done      = done_raw & clr_n;
    assign cmd_ready = ready_raw & clr_n;
    assign busy      = (state_q != ST_IDLE);
    assign res       = res_q;
    assign carry     = carry_q;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Command latch
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            op_q  <= OP_LDI;
            rd_q  <= '0;
            rs1_q <= '0;
            rs2_q <= '0;
            imm_q <= '0;
        end else if (accept) begin
            op_q  <= op_e'(cmd_op);
            rd_q  <= cmd_rd;
            rs1_q <= cmd_rs1;
            rs2_q <= cmd_rs2;
            imm_q <= cmd_imm;
        end
    end

    // ------------------------------------------------------------------
    // Operand capture: rf_q reflects rf_rsel within the same cycle
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            opa_q <= '0;
            opb_q <= '0;
        end else begin
            if (state_q == ST_RD1) begin
                opa_q <= rf_q;
            end
            if (state_q == ST_RD2) begin
                opb_q <= rf_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Result / carry, updated on the write-back edge
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            res_q   <= '0;
            carry_q <= 1'b0;
        end else if (state_q == ST_WB) begin
            res_q <= wb_data;
            if (op_q == OP_ADD) begin
                carry_q <= sum[DW];
            end else if (op_q == OP_CLR) begin
                carry_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reg8file_seq.sv
// Bench for reg8file_seq wired pin-to-pin to reg8file. A behavioural model (register array,
// result, carry and per-op latency) predicts every observable effect of each command.
module tb_reg8file_seq;

    localparam logic [1:0] LDI = 2'b00;
    localparam logic [1:0] MOV = 2'b01;
    localparam logic [1:0] ADD = 2'b10;
    localparam logic [1:0] CLR = 2'b11;

    logic       clk = 1'b0;
    logic       clr_n = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = '0;
    logic [2:0] cmd_rd = '0;
    logic [2:0] cmd_rs1 = '0;
    logic [2:0] cmd_rs2 = '0;
    logic [7:0] cmd_imm = '0;
    logic       rf_clr, rf_en;
    logic [2:0] rf_wsel, rf_rsel;
    logic [7:0] rf_d, rf_q;
    logic       busy, done;
    logic [7:0] res;
    logic       carry;

    int n_chk = 0;
    int n_bad = 0;

    // Reference model
    logic [7:0] m_regs [8];
    logic [7:0] m_res;
    logic       m_carry;

    always #5 clk = ~clk;

    reg8file_seq #(
        .DW           (8),
        .AW           (3),
        .CLR_ON_RESET (1'b1)
    ) u_dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_rd    (cmd_rd),
        .cmd_rs1   (cmd_rs1),
        .cmd_rs2   (cmd_rs2),
        .cmd_imm   (cmd_imm),
        .rf_clr    (rf_clr),
        .rf_en     (rf_en),
        .rf_wsel   (rf_wsel),
        .rf_d      (rf_d),
        .rf_rsel   (rf_rsel),
        .rf_q      (rf_q),
        .busy      (busy),
        .done      (done),
        .res       (res),
        .carry     (carry)
    );

    reg8file #(
        .DW (8),
        .AW (3)
    ) u_rf (
        .clk  (clk),
        .clr  (rf_clr),
        .en   (rf_en),
        .wsel (rf_wsel),
        .d    (rf_d),
        .rsel (rf_rsel),
        .q    (rf_q)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        m_res   = 8'h00;
        m_carry = 1'b0;
    endtask

    // Applies one command to the model; returns the value written (0 for CLR).
    task automatic model_apply(input logic [1:0] op, input int rd, input int rs1, input int rs2,
                               input logic [7:0] imm, output logic [7:0] wdata);
        int s;
        case (op)
            LDI: wdata = imm;
            MOV: wdata = m_regs[rs1];
            ADD: begin
                s       = int'(m_regs[rs1]) + int'(m_regs[rs2]);
                wdata   = s[7:0];
                m_carry = (s > 255);
            end
            default: wdata = 8'h00;
        endcase
        if (op == CLR) model_clear();
        else begin
            m_regs[rd] = wdata;
            m_res      = wdata;
        end
    endtask

    task automatic compare_all(input string ctx);
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("%s_r%0d", ctx, i), {24'h0, u_rf.regs_q[i]}, {24'h0, m_regs[i]});
        end
        check_eq({ctx, "_res"}, {24'h0, res}, {24'h0, m_res});
        check_eq({ctx, "_carry"}, {31'h0, carry}, {31'h0, m_carry});
    endtask

    // Entered and left at a falling clock edge.
    task automatic do_reset(input string ctx);
        int en_seen = 0;
        clr_n     = 1'b0;
        cmd_valid = 1'b0;
        #1;
        check_eq({ctx, "_rst_en"}, {31'h0, rf_en}, 32'd0);
        check_eq({ctx, "_rst_clr"}, {31'h0, rf_clr}, 32'd0);
        check_eq({ctx, "_rst_done"}, {31'h0, done}, 32'd0);
        check_eq({ctx, "_rst_ready"}, {31'h0, cmd_ready}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            en_seen += int'(rf_en);
        end
        check_eq({ctx, "_rst_en_cnt"}, en_seen, 32'd0);
        clr_n = 1'b1;
        #1;
        check_eq({ctx, "_init_clr"}, {31'h0, rf_clr}, 32'd1);
        check_eq({ctx, "_init_ready"}, {31'h0, cmd_ready}, 32'd0);
        @(negedge clk);
        check_eq({ctx, "_idle_clr"}, {31'h0, rf_clr}, 32'd0);
        check_eq({ctx, "_idle_ready"}, {31'h0, cmd_ready}, 32'd1);
        model_clear();
        compare_all(ctx);
    endtask

    // Offer one command and wait until it is accepted; returns at the falling edge
    // after the accept edge with cmd_valid dropped and the fields scrambled.
    task automatic offer(input logic [1:0] op, input int rd, input int rs1, input int rs2,
                         input logic [7:0] imm);
        int w = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_rd    = rd[2:0];
        cmd_rs1   = rs1[2:0];
        cmd_rs2   = rs2[2:0];
        cmd_imm   = imm;
        while (!cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check_eq("accept", {31'h0, cmd_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_rd    = 3'($urandom);
        cmd_rs1   = 3'($urandom);
        cmd_rs2   = 3'($urandom);
        cmd_imm   = 8'($urandom);
    endtask

    task automatic run_cmd(input logic [1:0] op, input int rd, input int rs1, input int rs2,
                           input logic [7:0] imm);
        int          lat = 1;
        int          en_cnt = 0;
        int          clr_cnt = 0;
        int          exp_lat;
        logic [7:0]  wdata;
        exp_lat = (op == MOV) ? 2 : (op == ADD) ? 3 : 1;
        offer(op, rd, rs1, rs2, imm);
        model_apply(op, rd, rs1, rs2, imm, wdata);
        forever begin
            en_cnt  += int'(rf_en);
            clr_cnt += int'(rf_clr);
            if (done || lat >= 10) break;
            @(negedge clk);
            lat++;
        end
        check_eq("done_seen", {31'h0, done}, 32'd1);
        check_eq($sformatf("latency_op%0d", op), lat, exp_lat);
        check_eq("wr_count", en_cnt, (op == CLR) ? 0 : 1);
        check_eq("clr_count", clr_cnt, (op == CLR) ? 1 : 0);
        if (op != CLR) begin
            check_eq("rf_wsel", {29'h0, rf_wsel}, rd);
            check_eq("rf_d", {24'h0, rf_d}, {24'h0, wdata});
        end
        @(negedge clk);
        check_eq("done_pulse", {31'h0, done}, 32'd0);
        check_eq("ready_after", {31'h0, cmd_ready}, 32'd1);
        compare_all("cmd");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         dn;
        int         w7;
        int         acc;
        int         en_seen;
        logic [7:0] wd;

        model_clear();
        @(negedge clk);
        do_reset("por");

        // Preload r5, then confirm the INIT clear wipes it.
        run_cmd(LDI, 5, 0, 0, 8'hAA);
        do_reset("preload");

        // LDI then MOV; carry must stay as it was.
        run_cmd(LDI, 3, 0, 0, 8'h5C);
        run_cmd(MOV, 6, 3, 0, 8'h00);

        // ADD with rd == rs1 and a carry out.
        run_cmd(LDI, 1, 0, 0, 8'hF0);
        run_cmd(LDI, 2, 0, 0, 8'h20);
        run_cmd(ADD, 1, 1, 2, 8'h00);
        check_eq("add_carry_dir", {31'h0, carry}, 32'd1);
        check_eq("add_res_dir", {24'h0, res}, 32'h10);

        // rs1 == rs2 == rd doubling.
        run_cmd(LDI, 4, 0, 0, 8'h41);
        run_cmd(ADD, 4, 4, 4, 8'h00);
        check_eq("dbl1", {24'h0, u_rf.regs_q[4]}, 32'h82);
        run_cmd(ADD, 4, 4, 4, 8'h00);
        check_eq("dbl2", {24'h0, u_rf.regs_q[4]}, 32'h04);
        check_eq("dbl2_carry", {31'h0, carry}, 32'd1);

        // LDI r7 held valid while an ADD is in flight.
        offer(ADD, 0, 1, 2, 8'h00);
        model_apply(ADD, 0, 1, 2, 8'h00, wd);
        model_apply(LDI, 7, 0, 0, 8'h11, wd);
        cmd_valid = 1'b1;
        cmd_op    = LDI;
        cmd_rd    = 3'd7;
        cmd_imm   = 8'h11;
        dn  = 0;
        w7  = 0;
        acc = 0;
        for (int k = 1; k <= 10; k++) begin
            dn += int'(done);
            w7 += int'(rf_en && rf_wsel == 3'd7);
            if (cmd_valid && cmd_ready) acc = k;
            @(posedge clk);
            @(negedge clk);
            if (acc != 0) cmd_valid = 1'b0;
        end
        check_eq("hold_accept_cycle", acc, 32'd4);
        check_eq("hold_done_count", dn, 32'd2);
        check_eq("hold_r7_writes", w7, 32'd1);
        compare_all("hold");

        // Random command stream.
        for (int n = 0; n < 80; n++) begin
            logic [1:0] op;
            op = ($urandom_range(0, 11) == 0) ? CLR : 2'($urandom_range(0, 2));
            run_cmd(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 7)), 8'($urandom));
        end

        // Reset during RD2 of an ADD: no write may follow.
        run_cmd(LDI, 1, 0, 0, 8'h33);
        run_cmd(LDI, 2, 0, 0, 8'hE0);
        offer(ADD, 5, 1, 2, 8'h00);
        en_seen = int'(rf_en);
        @(negedge clk);
        en_seen += int'(rf_en);
        check_eq("abort_in_rd2_busy", {31'h0, busy}, 32'd1);
        check_eq("abort_rd2_rsel", {29'h0, rf_rsel}, 32'd2);
        do_reset("abort");
        check_eq("abort_en_before", en_seen, 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
